core0_char_bridge: RTL and testbench
====================================

// Module: core0_char_bridge
// PURPOSE
//   Byte-stream bridge between a host character channel (UART RX/TX, sim stdin/stdout) and one core0 bus.
//   Input side buffers host bytes and presents them on the core's receiver_sends/receiver_datas handshake.
//   Output side acks global_send words on the core's sender bus and queues their low byte for the host.
//   Sits directly outside core0_base, replacing hand-written bench glue for the uforth console.
// PARAMETERS
//   WORD_WIDTH       32  core data word width; rx_data is zero-extended, tx_data low byte used
//   FIFO_ADDR_WIDTH  4   log2 depth of each byte FIFO (RX and TX each hold 2^FIFO_ADDR_WIDTH bytes)
// PORTS
//   clk          in   1                  clock, all state on rising edge
//   reset        in   1                  asynchronous, active-low reset (0 = in reset)
//   flush        in   1                  sync clear of both FIFOs and the presentation register
//   in_valid     in   1                  host byte available
//   in_data      in   8                  host byte
//   in_ready     out  1                  bridge accepts in_data this cycle
//   rx_send      out  1                  to core receiver_sends[i]: rx_data valid
//   rx_data      out  WORD_WIDTH         to core receiver_datas[i]: {zeros, byte}
//   rx_send_ack  in   1                  from core receiver_send_acks[i]
//   tx_enable    in   1                  from core sender_enables[i]
//   tx_send      in   1                  from core global_send
//   tx_data      in   WORD_WIDTH         from core global_data
//   tx_send_ack  out  1                  to core sender_send_acks[i]
//   out_valid    out  1                  byte available for host
//   out_data     out  8                  byte for host
//   out_ready    in   1                  host consumes out_data this cycle
//   rx_level     out  FIFO_ADDR_WIDTH+1  bytes in RX FIFO (excludes presentation register)
//   tx_level     out  FIFO_ADDR_WIDTH+1  bytes in TX FIFO
// BEHAVIOUR
//   Reset (reset=0): FIFOs empty, pointers 0, presentation reg IDLE; in_ready=0, rx_send=0, rx_data=0,
//     tx_send_ack=0, out_valid=0, out_data=0, levels=0. Takes effect immediately, mid-handshake included.
//   RX FIFO: in_ready = reset & ~rx_full; push on edge with in_valid & in_ready. Full from registered
//     level only; a same-cycle pop does not free space for a push.
//   Presentation register FSM, IDLE/HOLD:
//     IDLE: rx_send=0. On edge with push & FIFO empty, byte bypasses FIFO into reg -> HOLD
//       (rx_send high the cycle after the accepting edge, 1-cycle latency). Else FIFO non-empty -> pop into reg -> HOLD.
//     HOLD: rx_send=1, rx_data stable. Edge with rx_send_ack: FIFO non-empty -> pop next byte, stay HOLD
//       (back-to-back, rx_send stays 1); FIFO empty & push -> bypass, stay HOLD; else -> IDLE.
//     rx_send_ack while IDLE is ignored. Capacity = 2^FIFO_ADDR_WIDTH + 1 bytes.
//   TX side: tx_send_ack = reset & tx_enable & tx_send & ~tx_full (combinational, same cycle).
//     Each edge with tx_send_ack=1 pushes tx_data[7:0]; upper bits discarded. Core holding tx_send over
//     N acked edges yields N bytes. tx_enable=0 or full -> no ack, no push, core stalls.
//   TX FIFO: out_valid = ~tx_empty, out_data = head (show-ahead); pop on edge with out_valid & out_ready.
//   Pointers wrap modulo 2^FIFO_ADDR_WIDTH; levels count 0..2^FIFO_ADDR_WIDTH; full = level==2^A.
//   Simultaneous push+pop on a non-empty, non-full FIFO: level unchanged, both take effect.
//   flush=1: both FIFOs emptied, FSM -> IDLE; in_ready and tx_send_ack forced 0 that cycle; no push/pop.
// TESTING
//   Reset then host sends 0x41,0x42 on consecutive cycles, rx_send_ack tied 1 -> rx_data 0x41 then
//     0x42 on consecutive cycles, rx_send=1 from cycle after first accept, drops after 0x42.
//   rx_send_ack held 0, host streams 20 bytes (A=4) -> 17 accepted, in_ready=0, rx_level=16;
//     release ack -> all 17 delivered in order, no loss/duplicate.
//   tx_send=1 with tx_data=0xDEAD_BE48 held 3 acked cycles, out_ready=1 -> out_data 0x48 three times.
//   out_ready=0, core sends 17 words -> 16 acked, tx_send_ack=0 on 17th; one pop -> ack reasserts next cycle.
//   tx_enable=0 with tx_send=1 -> tx_send_ack=0, tx_level stays 0.
//   Drop reset to 0 while in HOLD with 5 queued RX bytes -> rx_send=0, rx_level=0 immediately; flush same.

Source files
------------

// File: rtl/core0_char_bridge.sv
// Byte-stream bridge between a host character channel and one core0 bus:
// host bytes are presented on the receiver handshake, sender words are queued as bytes for the host.

module core0_char_bridge_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              push_en, pop_en;

    assign push_en = push & ~flush;
    assign pop_en  = pop & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_en && !pop_en)      level_d = level_q + LVL_ONE;
            else if (pop_en && !push_en) level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
endmodule

module core0_char_bridge #(
    parameter int WORD_WIDTH      = 32,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    rx_send,
    output logic [WORD_WIDTH-1:0]   rx_data,
    input  logic                    rx_send_ack,
    input  logic                    tx_enable,
    input  logic                    tx_send,
    input  logic [WORD_WIDTH-1:0]   tx_data,
    output logic                    tx_send_ack,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    input  logic                    out_ready,
    output logic [FIFO_ADDR_WIDTH:0] rx_level,
    output logic [FIFO_ADDR_WIDTH:0] tx_level
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} pres_state_e;

    pres_state_e state_q, state_d;
    logic [7:0]  pres_q, pres_d;

    logic       rx_full, rx_empty, rx_push_req, rx_fifo_push, rx_pop, bypass;
    logic [7:0] rx_head;
    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic [WORD_WIDTH-1:0] unused_tx_word;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign in_ready    = reset & ~rx_full & ~flush;
    assign rx_push_req = in_valid & in_ready;
    assign rx_fifo_push = rx_push_req & ~bypass;

    always_comb begin
        state_d = state_q;
        pres_d  = pres_q;
        rx_pop  = 1'b0;
        bypass  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_push_req && rx_empty) begin
                        bypass  = 1'b1;
                        pres_d  = in_data;
                        state_d = HOLD;
                    end else if (!rx_empty) begin
                        rx_pop  = 1'b1;
                        pres_d  = rx_head;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (rx_send_ack) begin
                        if (!rx_empty) begin
                            rx_pop = 1'b1;
                            pres_d = rx_head;
                        end else if (rx_push_req) begin
                            bypass = 1'b1;
                            pres_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pres_q  <= '0;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
        end
    end

    core0_char_bridge_fifo #(.DATA_W(8), .ADDR_W(FIFO_ADDR_WIDTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (rx_fifo_push),
        .pop   (rx_pop),
        .wdata (in_data),
        .head  (rx_head),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_send = (state_q == HOLD);
    assign rx_data = rx_send ? {{(WORD_WIDTH-8){1'b0}}, pres_q} : '0;

    // Only the low byte of each sender word reaches the host.
    assign unused_tx_word = tx_data;
    assign tx_send_ack    = reset & tx_enable & tx_send & ~tx_full & ~flush;
    assign tx_pop         = out_valid & out_ready & ~flush;

    core0_char_bridge_fifo #(.DATA_W(8), .ADDR_W(FIFO_ADDR_WIDTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (tx_send_ack),
        .pop   (tx_pop),
        .wdata (tx_data[7:0]),
        .head  (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign out_valid = ~tx_empty;
    assign out_data  = tx_empty ? 8'h00 : tx_head;
endmodule

// File: tb/tb_core0_char_bridge.sv
// Directed bench for core0_char_bridge: RX presentation, RX/TX back-pressure, flush and async reset.

module tb_core0_char_bridge;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [7:0]  in_data;
    logic        rx_send, rx_send_ack, tx_enable, tx_send, tx_send_ack;
    logic [31:0] rx_data, tx_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [4:0]  rx_level, tx_level;

    int errors = 0;
    int checks = 0;
    int acc;

    always #5 clk = ~clk;

    core0_char_bridge #(.WORD_WIDTH(32), .FIFO_ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rx_send     (rx_send),
        .rx_data     (rx_data),
        .rx_send_ack (rx_send_ack),
        .tx_enable   (tx_enable),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_send_ack (tx_send_ack),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .rx_level    (rx_level),
        .tx_level    (tx_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        rx_send_ack = 1'b0; tx_enable = 1'b0; tx_send = 1'b0; tx_data = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rx_send", rx_send, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_levels", {rx_level, tx_level}, 0);
        tx_enable = 1'b1; tx_send = 1'b1;
        #1;
        chk("rst_tx_ack", tx_send_ack, 0);
        tx_send = 1'b0;
        reset = 1'b1;
        tick();

        // Two bytes back-to-back with ack tied high
        rx_send_ack = 1'b1;
        in_valid = 1'b1; in_data = 8'h41;
        #1;
        chk("bb_in_ready", in_ready, 1);
        tick();
        in_data = 8'h42;
        chk("bb_send0", rx_send, 1);
        chk("bb_data0", rx_data, 32'h41);
        tick();
        in_valid = 1'b0;
        chk("bb_send1", rx_send, 1);
        chk("bb_data1", rx_data, 32'h42);
        tick();
        chk("bb_drop", rx_send, 0);
        chk("bb_idle_data", rx_data, 0);

        // RX back-pressure: 17 bytes fit (16 queued plus presentation)
        rx_send_ack = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(acc);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 17);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_rx_level", rx_level, 16);
        rx_send_ack = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk("bp_order_send", rx_send, 1);
            chk("bp_order_data", rx_data, 32'h10 + k);
            tick();
        end
        chk("bp_done_send", rx_send, 0);
        chk("bp_done_level", rx_level, 0);
        rx_send_ack = 1'b0;

        // TX: word held three acked cycles, host always ready
        tx_enable = 1'b1; tx_send = 1'b1; tx_data = 32'hDEAD_BE48; out_ready = 1'b1;
        #1;
        chk("tx3_ack", tx_send_ack, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tx3_valid", out_valid, 1);
            chk("tx3_data", out_data, 32'h48);
            chk("tx3_level", tx_level, 1);
        end
        tx_send = 1'b0;
        tick();
        chk("tx3_empty", out_valid, 0);
        chk("tx3_level0", tx_level, 0);

        // TX back-pressure: 16 acked, 17th stalled until one pop
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tx_send = 1'b1;
            tx_data = 32'h0000_0160 + i;
            #1;
            chk("txf_ack", tx_send_ack, (i < 16) ? 1 : 0);
            tick();
        end
        chk("txf_level", tx_level, 16);
        chk("txf_stall", tx_send_ack, 0);
        chk("txf_head", out_data, 32'h60);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("txf_level15", tx_level, 15);
        chk("txf_reack", tx_send_ack, 1);
        chk("txf_head2", out_data, 32'h61);
        tx_send = 1'b0;

        // Flush blocks ack and empties TX
        tx_send = 1'b1; flush = 1'b1;
        #1;
        chk("fl_tx_ack", tx_send_ack, 0);
        tick();
        flush = 1'b0; tx_send = 1'b0;
        chk("fl_tx_level", tx_level, 0);
        chk("fl_out_valid", out_valid, 0);

        // Sender disabled
        tx_enable = 1'b0; tx_send = 1'b1;
        #1;
        chk("dis_ack", tx_send_ack, 0);
        tick();
        tick();
        chk("dis_level", tx_level, 0);
        tx_send = 1'b0;

        // Async reset while holding with 5 queued bytes
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("ar_level5", rx_level, 5);
        chk("ar_hold_data", rx_data, 32'h30);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_send", rx_send, 0);
        chk("ar_level", rx_level, 0);
        chk("ar_in_ready", in_ready, 0);
        tick();
        reset = 1'b1;
        tick();

        // Flush while holding with 5 queued bytes; a byte offered during flush is dropped
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(i);
            tick();
        end
        chk("sf_level5", rx_level, 5);
        flush = 1'b1;
        #1;
        chk("sf_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("sf_send", rx_send, 0);
        chk("sf_level", rx_level, 0);
        tick();
        chk("sf_still_idle", rx_send, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
